if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the multi-cycle core; sits directly downstream of the stage sequencer.
- Consumes the sequencer's stage_reset_n, if_id_wren and pc_wren strobes.
- Owns the PC, issues a single request per instruction to instruction memory (variable-latency req/rvalid handshake) and buffers the returned word.
- Loads the IF/ID register on if_id_wren; updates the PC (sequential or branch) on pc_wren.

---
 rtl/if_fetch_unit_pkg.sv | 16 +
 rtl/if_fetch_unit_pc.sv | 47 ++++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: datapath width, the NOP used on faults and stalls, and the
// fetch FSM state encodings.
package if_fetch_unit_pkg;

    localparam int               FETCH_XLEN = 32;
    localparam logic [31:0]      FETCH_NOP  = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_pc.sv
// if_pc_unit: program counter register and next-PC selection.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   pc_wren             update PC this cycle
//   branch_taken        take branch_target instead of pc+4
//   branch_target       branch destination
//   pc                  current PC
//   misalign            pulse: taken branch to a non-word-aligned target
module if_pc_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int             XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pc_wren,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_next;
    logic            target_ok;

    // Natural XLEN-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign pc_seq    = pc + XLEN'(4);
    assign target_ok = (branch_target[1:0] == 2'b00);
    assign misalign  = pc_wren & branch_taken & ~target_ok;

    // A misaligned target falls back to the sequential PC.
    always_comb begin
        pc_next = pc_seq;
        if (branch_taken && target_ok)
            pc_next = branch_target;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            pc <= RESET_PC;
        else if (pc_wren)
            pc <= pc_next;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the multi-cycle core.
// Issues one imem request per instruction, waits (bounded) for rvalid,
// buffers the word and loads the IF/ID register on the sequencer's strobe.
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   stage_reset_n                   per-instruction clear (low = back to IDLE)
//   if_id_wren, pc_wren             sequencer strobes
//   branch_taken, branch_target     next-PC selection, sampled on pc_wren
//   imem_req, imem_addr             fetch request (one cycle) and address
//   imem_rdata, imem_rvalid         fetch response
//   pc                              current PC
//   if_id_pc, if_id_instr,
//   if_id_valid                     IF/ID register
//   fetch_ready                     buffer holds a completed fetch
//   fetch_fault                     sticky: timeout or misaligned branch
//   stall_err                       sticky: IF/ID load before fetch_ready
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP,
    parameter int              TIMEOUT   = 15,
    parameter int              TO_W      = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stage_reset_n,
    input  logic            if_id_wren,
    input  logic            pc_wren,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_ready,
    output logic            fetch_fault,
    output logic            stall_err
);

    fetch_state_t    state;
    logic [TO_W-1:0] to_cnt;
    logic [XLEN-1:0] fetch_buf;
    logic            buf_genuine;   // 0 when the buffer holds a timeout NOP
    logic            pc_misalign;
    logic            bypass;

    if_pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_wren       (pc_wren),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .misalign      (pc_misalign)
    );

    assign imem_addr = pc;

    // Response arriving in the same cycle the sequencer loads IF/ID goes
    // straight through instead of counting as a stall.
    assign bypass = (state == FETCH_WAIT) && imem_rvalid && stage_reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH_IDLE;
            to_cnt      <= '0;
            fetch_buf   <= NOP_INSTR;
            buf_genuine <= 1'b0;
            imem_req    <= 1'b0;
            fetch_ready <= 1'b0;
            fetch_fault <= 1'b0;
            stall_err   <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            if (pc_misalign)
                fetch_fault <= 1'b1;

            // IF/ID register; captures the pre-update pc when pc_wren coincides.
            if (if_id_wren) begin
                if (fetch_ready) begin
                    if_id_instr <= fetch_buf;
                    if_id_pc    <= pc;
                    if_id_valid <= buf_genuine;
                end else if (bypass) begin
                    if_id_instr <= imem_rdata;
                    if_id_pc    <= pc;
                    if_id_valid <= 1'b1;
                end else begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    stall_err   <= 1'b1;
                end
            end

            // Fetch FSM; imem_req is registered so it is high exactly in REQ.
            if (!stage_reset_n) begin
                state       <= FETCH_IDLE;
                fetch_ready <= 1'b0;
                to_cnt      <= '0;
                imem_req    <= 1'b0;
            end else begin
                case (state)
                    FETCH_IDLE: begin
                        state    <= FETCH_REQ;
                        imem_req <= 1'b1;
                    end
                    FETCH_REQ: begin
                        imem_req <= 1'b0;
                        to_cnt   <= '0;
                        state    <= FETCH_WAIT;
                    end
                    FETCH_WAIT: begin
                        if (imem_rvalid) begin
                            fetch_buf   <= imem_rdata;
                            buf_genuine <= 1'b1;
                            fetch_ready <= 1'b1;
                            state       <= FETCH_HOLD;
                        end else if (to_cnt == TO_W'(TIMEOUT)) begin
                            fetch_buf   <= NOP_INSTR;
                            buf_genuine <= 1'b0;
                            fetch_fault <= 1'b1;
                            fetch_ready <= 1'b1;
                            state       <= FETCH_HOLD;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    FETCH_HOLD: ;
                    default: state <= FETCH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stage_reset_n = 1'b0;
    logic        if_id_wren = 1'b0;
    logic        pc_wren = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr, pc, if_id_pc, if_id_instr;
    logic        if_id_valid, fetch_ready, fetch_fault, stall_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;
    ifid_t exp_q[$];

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    if_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stage_reset_n (stage_reset_n),
        .if_id_wren    (if_id_wren),
        .pc_wren       (pc_wren),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_ready   (fetch_ready),
        .fetch_fault   (fetch_fault),
        .stall_err     (stall_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] p, input logic v);
        ifid_t e;
        e.instr = instr;
        e.pc    = p;
        e.valid = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string name);
        ifid_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, ".instr"}, if_id_instr, e.instr);
            chk({name, ".pc"},    if_id_pc,    e.pc);
            chk({name, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stage_reset_n = 1'b0;
        if_id_wren = 1'b0;
        pc_wren = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Start a fetch from any state; leaves the FSM in REQ.
    task automatic start_fetch(input string name, input logic [31:0] exp_addr);
        stage_reset_n = 1'b0;
        tick();
        stage_reset_n = 1'b1;
        tick();
        chk({name, ".req"},  {31'd0, imem_req}, 32'd1);
        chk({name, ".addr"}, imem_addr, exp_addr);
    endtask

    task automatic do_instr(input string name, input vec_t v);
        start_fetch(name, v.exp_addr);
        tick();  // WAIT
        chk({name, ".req_pulse"}, {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < v.lat; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = v.rdata;
        push(v.rdata, v.exp_addr, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        chk({name, ".ready"}, {31'd0, fetch_ready}, 32'd1);
        if_id_wren = 1'b1;
        tick();
        if_id_wren = 1'b0;
        pop_chk({name, ".ifid"});
        pc_wren       = 1'b1;
        branch_taken  = v.bt;
        branch_target = v.tgt;
        tick();
        pc_wren      = 1'b0;
        branch_taken = 1'b0;
        chk({name, ".pc"},    pc, v.exp_pc);
        chk({name, ".fault"}, {31'd0, fetch_fault}, {31'd0, v.exp_fault});
    endtask

    vec_t vecs[5];
    int   waited;

    initial begin
        vecs[0] = '{1, 32'h0050_0093, 1'b0, 32'h0,   32'h000, 32'h004, 1'b0};
        vecs[1] = '{3, 32'h0010_0113, 1'b0, 32'h0,   32'h004, 32'h008, 1'b0};
        vecs[2] = '{2, 32'h0020_81b3, 1'b1, 32'h100, 32'h008, 32'h100, 1'b0};
        vecs[3] = '{1, 32'h0000_0213, 1'b0, 32'h0,   32'h100, 32'h104, 1'b0};
        vecs[4] = '{1, 32'h0030_0293, 1'b1, 32'h102, 32'h104, 32'h108, 1'b1};

        // Reset state
        do_reset();
        chk("rst.pc",    pc, 32'h0);
        chk("rst.req",   {31'd0, imem_req}, 32'd0);
        chk("rst.instr", if_id_instr, NOP);
        chk("rst.ifpc",  if_id_pc, 32'h0);
        chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst.ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst.fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst.stall", {31'd0, stall_err}, 32'd0);

        // Sequential fetches and branches
        foreach (vecs[i]) do_instr($sformatf("vec%0d", i), vecs[i]);

        // Timeout
        do_reset();
        start_fetch("to", 32'h0);
        tick();  // WAIT
        for (int i = 0; i < 10; i++) tick();
        chk("to.early_ready", {31'd0, fetch_ready}, 32'd0);
        chk("to.early_fault", {31'd0, fetch_fault}, 32'd0);
        waited = 0;
        while (!fetch_ready && waited < 30) begin
            tick();
            waited++;
        end
        chk("to.ready", {31'd0, fetch_ready}, 32'd1);
        chk("to.fault", {31'd0, fetch_fault}, 32'd1);
        if_id_wren = 1'b1;
        push(NOP, 32'h0, 1'b0);
        tick();
        if_id_wren = 1'b0;
        pop_chk("to.ifid");

        // Stall: IF/ID load while IDLE
        do_reset();
        stage_reset_n = 1'b0;
        if_id_wren = 1'b1;
        push(NOP, 32'h0, 1'b0);
        tick();
        if_id_wren = 1'b0;
        chk("stall.err", {31'd0, stall_err}, 32'd1);
        pop_chk("stall.ifid");

        // Bypass: rvalid and if_id_wren in the same WAIT cycle
        start_fetch("byp", 32'h0);
        tick();  // WAIT
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hABCD_0037;
        if_id_wren  = 1'b1;
        push(32'hABCD_0037, 32'h0, 1'b1);
        tick();
        imem_rvalid = 1'b0;
        if_id_wren  = 1'b0;
        pop_chk("byp.ifid");
        chk("byp.ready", {31'd0, fetch_ready}, 32'd1);

        // Reset in the middle of WAIT at pc=0x40, then a late rvalid
        do_instr("to40", '{1, 32'h0000_0093, 1'b1, 32'h40, 32'h0, 32'h40, 1'b0});
        start_fetch("mid", 32'h40);
        tick();  // WAIT
        reset_n = 1'b0;
        tick();
        chk("mid.pc",    pc, 32'h0);
        chk("mid.req",   {31'd0, imem_req}, 32'd0);
        chk("mid.stall", {31'd0, stall_err}, 32'd0);
        chk("mid.fault", {31'd0, fetch_fault}, 32'd0);
        chk("mid.ready", {31'd0, fetch_ready}, 32'd0);
        reset_n = 1'b1;
        stage_reset_n = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("late.idle_ready", {31'd0, fetch_ready}, 32'd0);
        stage_reset_n = 1'b1;
        tick();  // REQ
        tick();  // WAIT; rvalid during REQ must not complete the fetch
        imem_rvalid = 1'b0;
        chk("late.req_ready", {31'd0, fetch_ready}, 32'd0);
        chk("late.fault",     {31'd0, fetch_fault}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
